// File: rtl/hf_block_mover_pkg.sv
// Shared definitions for the hyperfabric block mover: default widths,
// direction codes, FSM encoding and a direction-legality helper.
package hf_block_mover_pkg;

  localparam int HF_DW = 32;
  localparam int HF_AW = 9;
  localparam int HF_CW = 6;

  localparam logic [1:0] HF_DIR_RD = 2'b10;  // RAM -> stream
  localparam logic [1:0] HF_DIR_WR = 2'b01;  // stream -> RAM

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_RUN = 2'd1,
    ST_WR_RUN = 2'd2,
    ST_FIN    = 2'd3
  } hf_state_t;

  function automatic logic hf_dir_legal(input logic [1:0] dir);
    return (dir == HF_DIR_RD) || (dir == HF_DIR_WR);
  endfunction

endpackage

// File: rtl/hf_block_mover_skid2.sv
// Two-entry valid/ready buffer sitting behind the staging RAM read port.
// It remembers whether a read is in flight so that buffered plus in-flight
// words never exceed two, which lets the mover stream one word per cycle
// while still absorbing backpressure without dropping RAM data.
module hf_block_mover_skid2 #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          rd_issue,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          can_issue
);

  logic [DW-1:0] ent0, ent1;
  logic [1:0]    cnt;
  logic          pend;
  logic          push, pop;
  logic [2:0]    occ;

  assign out_valid = (cnt != 2'd0);
  assign out_data  = ent0;
  assign push      = pend && !flush;
  assign pop       = out_valid && out_ready && !flush;
  // occupancy after this edge if no new read is launched; a new read fits while it stays below 2
  assign occ       = 3'(cnt) + 3'(pend) - 3'(pop);
  assign can_issue = (occ < 3'd2) && !flush;

  // entry storage, fill count and in-flight tracking
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
      pend <= 1'b0;
    end else if (flush) begin
      cnt  <= 2'd0;
      pend <= 1'b0;
    end else begin
      pend <= rd_issue;
      unique case ({push, pop})
        2'b11: begin
          if (cnt == 2'd1) ent0 <= rd_data;
          else begin
            ent0 <= ent1;
            ent1 <= rd_data;
          end
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) ent0 <= rd_data;
          else             ent1 <= rd_data;
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hf_block_mover.sv
// Hyperfabric block mover: one RAM<->stream block transfer per issue.
// Status (count, IRQ, abort, device error) is final by the time
// BLCK_WORKING falls and is held until the next accepted issue.
module hf_block_mover
  import hf_block_mover_pkg::*;
#(
  parameter int DW = HF_DW,
  parameter int AW = HF_AW,
  parameter int CW = HF_CW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          BLCK_ISSUE,
  input  logic [AW-1:0] BLCK_START,
  input  logic [CW-1:0] BLCK_COUNT_REQ,
  input  logic [1:0]    BLCK_SECTION,
  input  logic [1:0]    RST_MVBLCK,
  input  logic          MCU_DEVERR,
  output logic          BLCK_WORKING,
  output logic [CW-1:0] BLCK_COUNT_SENT,
  output logic          BLCK_IRQ,
  output logic          BLCK_ABRUPT_STOP,
  output logic          BLCK_FRDRAM_DEVERR,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_RE,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WDATA,
  output logic [DW-1:0] SO_DATA,
  output logic          SO_VALID,
  output logic [1:0]    SO_TAG,
  input  logic          SO_READY,
  input  logic [DW-1:0] SI_DATA,
  input  logic          SI_VALID,
  input  logic          SI_LAST,
  output logic          SI_READY,
  input  logic          SX_ABORT
);

  hf_state_t     state, state_nx;
  logic [AW-1:0] start_q, wr_addr_q;
  logic [CW-1:0] req_q, sent_q, rd_iss_q;
  logic [1:0]    tag_q;
  logic          working_q, irq_q, abrupt_q, deverr_q;
  logic          wr_end_q, we_q;
  logic [DW-1:0] wdata_q;

  logic          issue_ok, stop_dev, stop_abort;
  logic          so_hs, si_hs, rd_last_hs, rd_stop, wr_final_hs, early_last;
  logic          skid_valid, skid_can, skid_flush;
  logic [DW-1:0] skid_data;

  assign issue_ok    = (state == ST_IDLE) && BLCK_ISSUE;
  assign stop_dev    = MCU_DEVERR;
  assign stop_abort  = SX_ABORT || (RST_MVBLCK == 2'b00);
  assign so_hs       = SO_VALID && SO_READY;
  assign si_hs       = SI_VALID && SI_READY;
  assign rd_last_hs  = so_hs && (sent_q + CW'(1) == req_q);
  assign rd_stop     = (state == ST_RD_RUN) && (stop_dev || stop_abort);
  assign wr_final_hs = si_hs && (sent_q + CW'(1) == req_q);
  assign early_last  = si_hs && SI_LAST && !wr_final_hs;
  assign skid_flush  = (state != ST_RD_RUN);

  hf_block_mover_skid2 #(.DW(DW)) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (skid_flush),
    .rd_issue  (MEM_RE),
    .rd_data   (MEM_RDATA),
    .out_data  (skid_data),
    .out_valid (skid_valid),
    .out_ready (SO_READY),
    .can_issue (skid_can)
  );

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // next-state: zero-length or illegal-direction issues go straight to FIN;
  // a write lingers one drain cycle after its end event so the last MEM_WE lands first
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (BLCK_ISSUE) begin
          if (BLCK_COUNT_REQ == '0 || !hf_dir_legal(RST_MVBLCK)) state_nx = ST_FIN;
          else if (RST_MVBLCK == HF_DIR_RD)                     state_nx = ST_RD_RUN;
          else                                                  state_nx = ST_WR_RUN;
        end
      end
      ST_RD_RUN: if (rd_stop || rd_last_hs) state_nx = ST_FIN;
      ST_WR_RUN: if (wr_end_q)              state_nx = ST_FIN;
      ST_FIN:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // stream and RAM-read handshake outputs decoded from state
  always_comb begin
    SO_VALID = 1'b0;
    SI_READY = 1'b0;
    MEM_RE   = 1'b0;
    unique case (state)
      ST_RD_RUN: begin
        SO_VALID = skid_valid;
        MEM_RE   = (rd_iss_q < req_q) && skid_can;
      end
      ST_WR_RUN: SI_READY = !wr_end_q && (sent_q < req_q);
      default: ;
    endcase
  end

  // latch the op parameters at an accepted issue and count launched reads
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      start_q  <= '0;
      req_q    <= '0;
      tag_q    <= 2'b00;
      rd_iss_q <= '0;
    end else if (issue_ok) begin
      start_q  <= BLCK_START;
      req_q    <= BLCK_COUNT_REQ;
      tag_q    <= BLCK_SECTION;
      rd_iss_q <= '0;
    end else if (MEM_RE) begin
      rd_iss_q <= rd_iss_q + CW'(1);
    end
  end

  // status: cleared at issue, one flag per op chosen by DEVERR > ABORT > LAST
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sent_q   <= '0;
      irq_q    <= 1'b0;
      abrupt_q <= 1'b0;
      deverr_q <= 1'b0;
      wr_end_q <= 1'b0;
    end else if (issue_ok) begin
      sent_q   <= '0;
      irq_q    <= 1'b0;
      abrupt_q <= !hf_dir_legal(RST_MVBLCK);
      deverr_q <= 1'b0;
      wr_end_q <= 1'b0;
    end else if (state == ST_RD_RUN) begin
      if (so_hs) sent_q <= sent_q + CW'(1);
      if (stop_dev)        deverr_q <= 1'b1;
      else if (stop_abort) abrupt_q <= 1'b1;
    end else if (state == ST_WR_RUN && !wr_end_q) begin
      if (si_hs) sent_q <= sent_q + CW'(1);
      if (stop_dev || stop_abort || early_last || wr_final_hs) wr_end_q <= 1'b1;
      if (stop_dev)        deverr_q <= 1'b1;
      else if (stop_abort) abrupt_q <= 1'b1;
      else if (early_last) irq_q    <= 1'b1;
    end
  end

  // WORKING rises after issue and falls as the op enters (or leaves) FIN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                         working_q <= 1'b0;
    else if (issue_ok)                                working_q <= 1'b1;
    else if (state_nx == ST_FIN || state == ST_FIN)   working_q <= 1'b0;
  end

  // registered RAM write, one cycle after each accepted stream-in word
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
    end else begin
      we_q <= si_hs;
      if (si_hs) begin
        wr_addr_q <= start_q + AW'(sent_q);
        wdata_q   <= SI_DATA;
      end
    end
  end

  assign MEM_ADDR           = MEM_RE ? start_q + AW'(rd_iss_q) : wr_addr_q;
  assign MEM_WE             = we_q;
  assign MEM_WDATA          = wdata_q;
  assign SO_DATA            = skid_data;
  assign SO_TAG             = tag_q;
  assign BLCK_WORKING       = working_q;
  assign BLCK_COUNT_SENT    = sent_q;
  assign BLCK_IRQ           = irq_q;
  assign BLCK_ABRUPT_STOP   = abrupt_q;
  assign BLCK_FRDRAM_DEVERR = deverr_q;

endmodule
